iccm_ctrl: RTL and testbench

//  Sequences and shares the single-port ICCM between a boot loader, instruction fetch (IF) and load/store (LS).

---
 rtl/iccm_ctrl.sv | 122 ++++++++++++
 tb/tb_iccm_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_ctrl.sv
// ICCM sequencer: boot-loader writes, then round-robin IF/LS sharing.
// Define ICCM_WR_PROTECT_EN to reject LS stores in RUN with ls_err.
module iccm_ctrl #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 ld_valid,
    input  logic [AddrWidth-1:0] ld_addr,
    input  logic [DataWidth-1:0] ld_wdata,
    input  logic                 ld_done,
    output logic                 ld_ready,
    input  logic                 if_req,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DataWidth-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [AddrWidth-1:0] ls_addr,
    input  logic [DataWidth-1:0] ls_wdata,
    output logic                 ls_gnt,
    output logic                 ls_rvalid,
    output logic [DataWidth-1:0] ls_rdata,
    output logic                 ls_err,
    output logic [AddrWidth-1:0] iccm_addr,
    output logic                 iccm_read,
    output logic                 iccm_write,
    output logic [DataWidth-1:0] iccm_wdata,
    input  logic [DataWidth-1:0] iccm_rdata,
    output logic                 boot_done,
    output logic [AddrWidth:0]   ld_count
);

    typedef enum logic {BOOT, RUN} state_e;

    localparam logic [AddrWidth:0] LdMax = {1'b1, {AddrWidth{1'b0}}};

    state_e state;
    logic   run;
    logic   last_gnt_ls;
    logic   ls_store;
    logic   ls_wr_en;

    assign run       = (state == RUN);
    assign boot_done = run;
    assign ld_ready  = ~run & ld_valid;
    assign ls_store  = ls_gnt & ls_we;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (run) begin
            if_gnt = if_req & (~ls_req | last_gnt_ls);
            ls_gnt = ls_req & (~if_req | ~last_gnt_ls);
        end
    end

    always_comb begin
        iccm_addr  = '0;
        iccm_read  = 1'b0;
        iccm_write = 1'b0;
        iccm_wdata = '0;
        if (ld_ready) begin
            iccm_write = 1'b1;
            iccm_addr  = ld_addr;
            iccm_wdata = ld_wdata;
        end else if (if_gnt) begin
            iccm_read = 1'b1;
            iccm_addr = if_addr;
        end else if (ls_gnt) begin
            iccm_addr  = ls_addr;
            iccm_read  = ~ls_we;
            iccm_write = ls_wr_en;
            iccm_wdata = ls_wr_en ? ls_wdata : '0;
        end
    end

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            state       <= BOOT;
            last_gnt_ls <= 1'b1;
            if_rvalid   <= 1'b0;
            ls_rvalid   <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            ld_count    <= '0;
        end else begin
            if (!run && ld_done)
                state <= RUN;
            if (if_gnt)
                last_gnt_ls <= 1'b0;
            else if (ls_gnt)
                last_gnt_ls <= 1'b1;
            if_rvalid <= if_gnt;
            ls_rvalid <= ls_gnt;
            if (if_gnt)
                if_rdata <= iccm_rdata;
            if (ls_gnt)
                ls_rdata <= ls_we ? '0 : iccm_rdata;
            if (ld_ready && ld_count != LdMax)
                ld_count <= ld_count + 1'b1;
        end
    end

`ifdef ICCM_WR_PROTECT_EN
    assign ls_wr_en = 1'b0;

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst)
            ls_err <= 1'b0;
        else
            ls_err <= ls_store;
    end
`else
    assign ls_wr_en = ls_store;
    assign ls_err   = 1'b0;
`endif

endmodule

// File: tb/tb_iccm_ctrl.sv
// Scoreboard bench for iccm_ctrl with a small ICCM model (AddrWidth=4).
module tb_iccm_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
`ifdef ICCM_WR_PROTECT_EN
    localparam bit Prot = 1'b1;
`else
    localparam bit Prot = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } ls_exp_t;

    logic          clk, rst;
    logic          ld_valid, ld_done, ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [AW-1:0] iccm_addr;
    logic          iccm_read, iccm_write;
    logic [DW-1:0] iccm_wdata, iccm_rdata;
    logic          boot_done;
    logic [AW:0]   ld_count;

    logic [DW-1:0] mem [16];
    logic          mem_init;
    logic [DW-1:0] if_q [$];
    ls_exp_t       ls_q [$];
    int            checks = 0;
    int            errors = 0;

    iccm_ctrl #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .brq_clk(clk), .brq_rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_ready(ld_ready),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .iccm_addr(iccm_addr), .iccm_read(iccm_read),
        .iccm_write(iccm_write), .iccm_wdata(iccm_wdata),
        .iccm_rdata(iccm_rdata),
        .boot_done(boot_done), .ld_count(ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign iccm_rdata = mem[iccm_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= 32'h1000_0000 + i;
        end else if (iccm_write) begin
            mem[iccm_addr] <= iccm_wdata;
        end
    end

    // Response monitor: every rvalid pops the oldest expected response.
    always @(negedge clk) begin
        if (!rst && if_rvalid) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++;
                $display("FAIL if_rvalid_unexpected got=1 exp=0");
            end else begin
                logic [DW-1:0] e;
                e = if_q.pop_front();
                if (if_rdata !== e) begin
                    errors++;
                    $display("FAIL if_rdata got=%h exp=%h", if_rdata, e);
                end
            end
        end
        if (!rst && ls_rvalid) begin
            checks++;
            if (ls_q.size() == 0) begin
                errors++;
                $display("FAIL ls_rvalid_unexpected got=1 exp=0");
            end else begin
                ls_exp_t e;
                e = ls_q.pop_front();
                if (ls_rdata !== e.d || ls_err !== e.e) begin
                    errors++;
                    $display("FAIL ls_resp got=%h/%b exp=%h/%b",
                             ls_rdata, ls_err, e.d, e.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input logic eif, input logic els,
                        input logic [DW-1:0] dif,
                        input logic [DW-1:0] dls, input logic eerr);
        ls_exp_t x;
        @(negedge clk);
        checks++;
        if (if_gnt !== eif || ls_gnt !== els) begin
            errors++;
            $display("FAIL gnt got=%b%b exp=%b%b",
                     if_gnt, ls_gnt, eif, els);
        end
        if (eif) if_q.push_back(dif);
        if (els) begin
            x.d = dls;
            x.e = eerr;
            ls_q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || ls_err !== 1'b0 ||
            if_rdata !== '0 || ls_rdata !== '0 || ld_count !== '0 ||
            boot_done !== 1'b0 || iccm_write !== 1'b0 ||
            iccm_read !== 1'b0 || iccm_addr !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b cnt=%0d bd=%b exp=0",
                     if_rvalid, ls_rvalid, ls_err, ld_count, boot_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
    endtask

    task automatic test_boot();
        if_req  = 1'b1;
        if_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(i);
            ld_wdata = 32'h0050_0293 + i;
            ld_done  = (i == 3);
            #1;
            checks++;
            if (ld_ready !== 1'b1 || iccm_write !== 1'b1 ||
                iccm_addr !== AW'(i) || iccm_wdata !== ld_wdata ||
                boot_done !== 1'b0) begin
                errors++;
                $display("FAIL boot_write i=%0d got=%b%b a=%0d bd=%b exp=110",
                         i, ld_ready, iccm_write, iccm_addr, boot_done);
            end
            step(1'b0, 1'b0, '0, '0, 1'b0);
        end
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        if_req   = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_count !== 5'd4 || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL boot_done got=%0d/%b exp=4/1", ld_count, boot_done);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b1;
        ld_addr  = 4'd9;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || iccm_write !== 1'b0) begin
            errors++;
            $display("FAIL run_ld_ignored got=%b%b exp=00", ld_ready, iccm_write);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0);
        ld_valid = 1'b0;
    endtask

    task automatic test_conflict();
        if_req  = 1'b1;
        if_addr = 4'd1;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 4'd3;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                step(1'b1, 1'b0, 32'h0050_0294, '0, 1'b0);
            else
                step(1'b0, 1'b1, '0, 32'h0050_0296, 1'b0);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 4'd2;
        #1;
        checks++;
        if (iccm_read !== 1'b1 || iccm_addr !== 4'd2 || iccm_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch_iccm got=%b a=%0d exp=1 a=2", iccm_read, iccm_addr);
        end
        step(1'b1, 1'b0, 32'h0050_0295, '0, 1'b0);
        if_addr = 4'd0;
        step(1'b1, 1'b0, 32'h0050_0293, '0, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_store();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 4'd5;
        ls_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (iccm_write !== !Prot || iccm_read !== 1'b0) begin
            errors++;
            $display("FAIL store_iccm got=%b exp=%b", iccm_write, !Prot);
        end
        step(1'b0, 1'b1, '0, '0, Prot);
        ls_we = 1'b0;
        step(1'b0, 1'b1, '0, Prot ? 32'h1000_0005 : 32'hDEAD_BEEF, 1'b0);
        ls_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset_inflight();
        if_req  = 1'b1;
        if_addr = 4'd0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL inflight_gnt got=%b exp=1", if_gnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        checks++;
        if (if_rvalid !== 1'b0 || boot_done !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("FAIL inflight_drop got=%b/%b/%0d exp=0/0/0",
                     if_rvalid, boot_done, ld_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_req = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b0);
        if_req = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 19; i++) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(i);
            ld_wdata = 32'h1000_0000 + (i % 16);
            @(posedge clk);
            #1;
            if (i == 14) begin
                checks++;
                if (ld_count !== 5'd15) begin
                    errors++;
                    $display("FAIL ld_count_mid got=%0d exp=15", ld_count);
                end
            end
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_count !== 5'd16 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL ld_count_sat got=%0d/%b exp=16/0", ld_count, boot_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        ld_valid = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_boot();
        test_conflict();
        test_fetch();
        test_store();
        test_reset_inflight();
        test_saturate();
        checks++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rvalid got=%0d/%0d exp=0/0",
                     if_q.size(), ls_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
